shift_reg_collect_right: RTL

Serial-to-parallel collector. The receiving end of the LSB-first serial bit stream produced by the right-shifting load/shift register in the mod_exp datapath. It accumulates WIDTH valid bits into a parallel word and flags completion. A consumer then acknowledges or restarts it. It sits on the result/readback side of the modular exponentiation core, and in loopback benches it sits directly on the shift register's shift_out.

---
 rtl/mod_exp_pkg.sv | 18 +
 rtl/bit_counter.sv | 29 ++
 rtl/shift_reg_collect_right.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mod_exp_pkg.sv
// Shared definitions for the mod_exp datapath: default word width, collector
// state encoding and the counter-width helper.
package mod_exp_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit counter for the serial collector: sync clear, count enable, and a
// terminal flag when the next accepted bit completes the word.
module bit_counter
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_reg_collect_right.sv
// Serial-to-parallel collector for the LSB-first stream of the right-shifting
// load/shift register; assembles WIDTH valid bits into data_out.
module shift_reg_collect_right
  import mod_exp_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             shift_in_valid,
  input  logic             shift_in,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             cnt_clear;
  logic             cnt_en;
  logic             term;

  assign shifted = {shift_in, sreg[WIDTH-1:1]};

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (bit_count),
    .term  (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority start > ack > shift_in_valid in every state.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_COLLECT;
          cnt_clear  = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (start) begin
          cnt_clear = 1'b1;
        end else if (shift_in_valid) begin
          cnt_en = 1'b1;
          if (term) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_COLLECT;
          cnt_clear  = 1'b1;
        end else if (ack) begin
          state_next = ST_IDLE;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg     <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= (state_next == ST_DONE);
      busy <= (state_next == ST_COLLECT);
      if (start) begin
        sreg    <= '0;
        overrun <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_COLLECT: begin
            if (shift_in_valid) begin
              sreg <= shifted;
              if (term) begin
                data_out <= shifted;
              end
            end
          end
          ST_DONE: begin
            if (shift_in_valid && !ack) begin
              overrun <= 1'b1;
            end
          end
          default: sreg <= '0;
        endcase
      end
    end
  end

endmodule
